// File: rtl/axi_stream_extract_header_if.sv
// rtl/axi_stream_extract_header_if.sv - token, input, header and payload channels of the header extractor
interface axi_stream_extract_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_extract;
    logic [BYTE_CNT_WD-1:0]  byte_extract_cnt;
    logic                    ready_extract;

    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_hdr;
    logic [DATA_WD-1:0]      data_hdr;
    logic [DATA_BYTE_WD-1:0] keep_hdr;
    logic                    short_hdr;
    logic                    ready_hdr;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    modport master (
        output valid_extract, byte_extract_cnt, valid_in, data_in, keep_in, last_in,
               ready_hdr, ready_out,
        input  ready_extract, ready_in, valid_hdr, data_hdr, keep_hdr, short_hdr,
               valid_out, data_out, keep_out, last_out
    );

    modport slave (
        input  valid_extract, byte_extract_cnt, valid_in, data_in, keep_in, last_in,
               ready_hdr, ready_out,
        output ready_extract, ready_in, valid_hdr, data_hdr, keep_hdr, short_hdr,
               valid_out, data_out, keep_out, last_out
    );
endinterface

// File: rtl/axi_stream_extract_header.sv
// rtl/axi_stream_extract_header.sv - strips n leading bytes into a header channel and re-aligns the payload
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic clk,
    input logic rst,
    axi_stream_extract_header_if.slave bus
);
    localparam int W  = DATA_BYTE_WD;
    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_FLUSH} state_t;

    state_t              r_state, w_state_next;
    logic [CW-1:0]       r_n;
    logic [DATA_WD-1:0]  r_res;
    logic [CW-1:0]       r_res_cnt;
    logic                r_hdr_valid, r_hdr_short;
    logic [DATA_WD-1:0]  r_hdr_data;
    logic [W-1:0]        r_hdr_keep;
    logic                r_out_valid, r_out_last;
    logic [DATA_WD-1:0]  r_out_data;
    logic [W-1:0]        r_out_keep;

    logic                w_ready_extract, w_ready_in;
    logic [CW-1:0]       w_k, w_r, w_hn, w_hdr_drop;
    logic [DATA_WD-1:0]  w_data_m;
    logic                w_tok_fire, w_in_fire, w_out_free;

    function automatic logic [W-1:0] msb_mask(input logic [CW-1:0] c);
        return ~(ALL_ONES >> c);
    endfunction

    function automatic logic [W-1:0] lsb_mask(input logic [CW-1:0] c);
        return ~(ALL_ONES << c);
    endfunction

    // Lanes outside keep_in are zeroed so garbage never reaches either output.
    always_comb begin
        w_k      = '0;
        w_data_m = '0;
        for (int i = 0; i < W; i++) begin
            w_k = w_k + CW'(bus.keep_in[i]);
            w_data_m[8*i +: 8] = bus.data_in[8*i +: 8] & {8{bus.keep_in[i]}};
        end
    end

    assign w_r        = CW'(W) - r_n;
    assign w_hn       = (w_k < r_n) ? w_k : r_n;
    assign w_hdr_drop = CW'(W) - w_hn;
    assign w_tok_fire = bus.valid_extract && w_ready_extract;
    assign w_in_fire  = bus.valid_in && w_ready_in;
    assign w_out_free = !r_out_valid || bus.ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_ready_extract = 1'b0;
        w_ready_in      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_extract = 1'b1;
                if (w_tok_fire) w_state_next = S_HDR;
            end
            S_HDR: begin
                w_ready_in = !r_hdr_valid;
                if (w_in_fire) begin
                    if (bus.last_in && w_k <= r_n) w_state_next = S_IDLE;
                    else if (bus.last_in)          w_state_next = S_FLUSH;
                    else                           w_state_next = S_BODY;
                end
            end
            S_BODY: begin
                w_ready_in = w_out_free;
                if (w_in_fire && bus.last_in)
                    w_state_next = (w_k <= r_n) ? S_IDLE : S_FLUSH;
            end
            default: begin
                if (w_out_free) w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n         <= '0;
            r_res       <= '0;
            r_res_cnt   <= '0;
            r_hdr_valid <= 1'b0;
            r_hdr_short <= 1'b0;
            r_hdr_data  <= '0;
            r_hdr_keep  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
        end else begin
            if (w_tok_fire) r_n <= {1'b0, bus.byte_extract_cnt} + CW'(1);
            if (r_hdr_valid && bus.ready_hdr) r_hdr_valid <= 1'b0;
            if (r_out_valid && bus.ready_out) r_out_valid <= 1'b0;
            case (r_state)
                S_HDR: if (w_in_fire) begin
                    r_hdr_valid <= 1'b1;
                    r_hdr_data  <= w_data_m >> {w_hdr_drop, 3'b000};
                    r_hdr_keep  <= lsb_mask(w_hn);
                    r_hdr_short <= bus.last_in && (w_k < r_n);
                    r_res       <= w_data_m << {r_n, 3'b000};
                    r_res_cnt   <= (w_k > r_n) ? w_k - r_n : '0;
                end
                S_BODY: if (w_in_fire) begin
                    // Carried r bytes on top, the first n bytes of this beat below them.
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_res | (w_data_m >> {w_r, 3'b000});
                    r_res       <= w_data_m << {r_n, 3'b000};
                    r_out_keep  <= ALL_ONES;
                    r_out_last  <= 1'b0;
                    if (bus.last_in) begin
                        if (w_k <= r_n) begin
                            r_out_keep <= msb_mask(w_r + w_k);
                            r_out_last <= 1'b1;
                        end else begin
                            r_res_cnt  <= w_k - r_n;
                        end
                    end
                end
                S_FLUSH: if (w_out_free) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_res;
                    r_out_keep  <= msb_mask(r_res_cnt);
                    r_out_last  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_extract = w_ready_extract;
    assign bus.ready_in      = w_ready_in;
    assign bus.valid_hdr     = r_hdr_valid;
    assign bus.data_hdr      = r_hdr_data;
    assign bus.keep_hdr      = r_hdr_keep;
    assign bus.short_hdr     = r_hdr_short;
    assign bus.valid_out     = r_out_valid;
    assign bus.data_out      = r_out_data;
    assign bus.keep_out      = r_out_keep;
    assign bus.last_out      = r_out_last;
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb/tb_axi_stream_extract_header.sv - randomized bench for the header extractor against a byte-level model
module tb_axi_stream_extract_header;
    localparam int W = 4;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last;}    beat_t;
    typedef struct packed {logic [31:0] data; logic [3:0] keep; logic short_f;} hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   bp_en    = 1'b0;
    bit   mon_en   = 1'b1;
    bit   out_held = 1'b0;
    bit   hdr_held = 1'b0;
    logic [37:0] out_saved, hdr_saved;
    beat_t exp_out[$];
    hdr_t  exp_hdr[$];

    axi_stream_extract_header_if #(.DATA_WD(32)) bus ();
    axi_stream_extract_header #(.DATA_WD(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Header = first min(n,len) bytes right-aligned; payload = bytes from n on, packed MSB-first.
    task automatic model_push(input int n, input byte_q_t b);
        hdr_t  h;
        beat_t o;
        int    m, p;
        m = (b.size() < n) ? b.size() : n;
        h = '0;
        for (int j = 0; j < m; j++) h.data = (h.data << 8) | 32'(b[j]);
        h.keep    = 4'((1 << m) - 1);
        h.short_f = (b.size() < n);
        exp_hdr.push_back(h);
        p = n;
        while (p < b.size()) begin
            o = '0;
            for (int i = 0; i < W; i++) begin
                o.data = o.data << 8;
                o.keep = o.keep << 1;
                if (p < b.size()) begin
                    o.data[7:0] = b[p];
                    o.keep[0]   = 1'b1;
                    p++;
                end
            end
            o.last = (p >= b.size());
            exp_out.push_back(o);
        end
    endtask

    task automatic send_token(input int n);
        int t = 0;
        bus.valid_extract    = 1'b1;
        bus.byte_extract_cnt = 2'(n - 1);
        while (!bus.ready_extract && t < 2000) begin @(negedge clk); #1; t++; end
        if (t >= 2000) check("token_timeout", 0, 1);
        @(negedge clk); #1;
        bus.valid_extract = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        while (!bus.ready_in && t < 2000) begin @(negedge clk); #1; t++; end
        if (t >= 2000) check("ready_in_timeout", 0, 1);
        @(negedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic send_packet(input int n, input byte_q_t b);
        int nb;
        logic [31:0] d;
        logic [3:0]  k;
        model_push(n, b);
        send_token(n);
        nb = (b.size() + W - 1) / W;
        for (int bi = 0; bi < nb; bi++) begin
            if (bp_en) repeat ($urandom_range(0, 1)) begin @(negedge clk); #1; end
            d = $urandom;
            k = '0;
            for (int i = 0; i < W; i++)
                if (bi * W + i < b.size()) begin
                    d[8*(W-1-i) +: 8] = b[bi*W + i];
                    k[W-1-i] = 1'b1;
                end
            drive_beat(d, k, bi == nb - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_out.size() != 0 || exp_hdr.size() != 0) && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        check("drain_out", 64'(exp_out.size()), 0);
        check("drain_hdr", 64'(exp_hdr.size()), 0);
    endtask

    always @(negedge clk) begin : mon_out
        beat_t e;
        bus.ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!mon_en) out_held = 1'b0;
        else begin
            if (out_held)
                check("out_stable", {bus.valid_out, bus.data_out, bus.keep_out, bus.last_out}, out_saved);
            if (bus.valid_out && bus.ready_out) begin
                out_held = 1'b0;
                if (exp_out.size() == 0) check("out_unexpected", 1, 0);
                else begin
                    e = exp_out.pop_front();
                    check("out_data", bus.data_out, e.data);
                    check("out_keep", bus.keep_out, e.keep);
                    check("out_last", bus.last_out, e.last);
                end
            end else if (bus.valid_out) begin
                out_held  = 1'b1;
                out_saved = {bus.valid_out, bus.data_out, bus.keep_out, bus.last_out};
            end else out_held = 1'b0;
        end
    end

    always @(negedge clk) begin : mon_hdr
        hdr_t e;
        bus.ready_hdr = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!mon_en) hdr_held = 1'b0;
        else begin
            if (hdr_held)
                check("hdr_stable", {bus.valid_hdr, bus.data_hdr, bus.keep_hdr, bus.short_hdr}, hdr_saved);
            if (bus.valid_hdr && bus.ready_hdr) begin
                hdr_held = 1'b0;
                if (exp_hdr.size() == 0) check("hdr_unexpected", 1, 0);
                else begin
                    e = exp_hdr.pop_front();
                    check("hdr_data", bus.data_hdr, e.data);
                    check("hdr_keep", bus.keep_hdr, e.keep);
                    check("hdr_short", bus.short_hdr, e.short_f);
                end
            end else if (bus.valid_hdr) begin
                hdr_held  = 1'b1;
                hdr_saved = {bus.valid_hdr, bus.data_hdr, bus.keep_hdr, bus.short_hdr};
            end else hdr_held = 1'b0;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        check("watchdog", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready_extract"}, bus.ready_extract, 1);
        check({tag, "_ready_in"},      bus.ready_in, 0);
        check({tag, "_valid_hdr"},     bus.valid_hdr, 0);
        check({tag, "_data_hdr"},      bus.data_hdr, 0);
        check({tag, "_keep_hdr"},      bus.keep_hdr, 0);
        check({tag, "_short_hdr"},     bus.short_hdr, 0);
        check({tag, "_valid_out"},     bus.valid_out, 0);
        check({tag, "_data_out"},      bus.data_out, 0);
        check({tag, "_keep_out"},      bus.keep_out, 0);
        check({tag, "_last_out"},      bus.last_out, 0);
    endtask

    initial begin
        byte_q_t q;
        int      len;
        bus.valid_extract = 1'b0; bus.byte_extract_cnt = '0;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk); #1;

        q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1};
        send_packet(2, q);
        q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
              8'h18, 8'h19, 8'h1A, 8'h1B, 8'hD0};
        send_packet(4, q);
        q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2};
        send_packet(1, q);
        q = '{8'hA0, 8'hA1};
        send_packet(3, q);
        q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_packet(3, q);
        drain();

        bp_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            q   = {};
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            send_packet($urandom_range(1, 4), q);
        end
        drain();
        bp_en = 1'b0;

        // Reset lands between clock edges while a payload beat is pending.
        repeat (2) @(negedge clk);
        #1;
        mon_en = 1'b0;
        send_token(1);
        drive_beat(32'h11223344, 4'hF, 1'b0);
        drive_beat(32'h55667788, 4'hF, 1'b0);
        #2;
        check("pre_rst_valid_out", bus.valid_out, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk); #1;
        q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8};
        send_packet(2, q);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
